writeback_commit: RTL and testbench
===================================

Name: writeback_commit

Overview:
- Per-issue-slot result collector.
- Arbitrates completed result packets from the execute units (ALU, LSU, FPU, SFU) and drives the writeback interface that the issue stage's scoreboard and operand register file consume.
- It is the transmitter side of writeback: it releases scoreboard reservations and writes the GPRs.
- The parent instantiates one copy per issue slot; the block also keeps committed-instruction counters.

Parameters:
- NUM_SRCS, 4, number of execute-unit result inputs (index 0 = ALU … 3 = SFU).
- NUM_THREADS, 4, lanes per warp.
- XLEN, 32, datapath width.
- NW_WIDTH, 2, warp-id width within the slot.
- NR_BITS, 6, register-index width.
- UUID_WIDTH, 44, instruction uuid width.
- CTR_BITS, 44, commit counter width.

Ports:
- clk in 1 clock
- reset in 1 synchronous active-high reset
- res_valid in NUM_SRCS per-source result valid
- res_ready out NUM_SRCS per-source accept
- res_uuid in NUM_SRCS*UUID_WIDTH instruction uuid
- res_wid in NUM_SRCS*NW_WIDTH warp id
- res_tmask in NUM_SRCS*NUM_THREADS thread mask
- res_pc in NUM_SRCS*XLEN PC
- res_wb in NUM_SRCS writes-register flag
- res_rd in NUM_SRCS*NR_BITS destination register
- res_data in NUM_SRCS*NUM_THREADS*XLEN per-lane result
- res_eop in NUM_SRCS last packet of instruction
- wb_valid out 1 writeback valid (no back-pressure)
- wb_uuid, wb_wid, wb_tmask, wb_pc, wb_rd, wb_data, wb_eop out (matching widths) writeback payload
- commit_instrs out CTR_BITS count of instructions completed (eop packets)
- commit_threads out CTR_BITS sum of active lanes over eop packets

Behaviour:
- One clock; reset is synchronous and active-high (clk, reset).
- Arbitration: round-robin over sources with res_valid=1. Exactly one grant per cycle when any source is valid.
  - res_ready[i] = grant[i], combinational from res_valid and the priority pointer.
  - res_ready never asserts for an invalid source.
- Priority pointer:
  - Resets to 0.
  - On a grant to i, it becomes (i+1) mod NUM_SRCS.
  - Unchanged when there is no grant.
  - Search order: pointer, pointer+1, … wrapping.
- Output register, latency 1: a packet granted in cycle N appears on wb_* in cycle N+1.
  - wb_valid(N+1) = granted(N) AND res_wb of the grantee.
  - A granted packet with wb=0 is consumed and counted but produces wb_valid=0.
- wb_* payload loads only on a grant. Payload holds its value otherwise (valid is the qualifier).
- Writeback has no ready, so the block never stalls for output. Throughput is one packet per cycle.
- Multi-packet instructions (eop=0 beats) may interleave with other sources. No lock is held; each beat is independently arbitrated.
- Counters:
  - On a grant with res_eop=1, commit_instrs += 1 and commit_threads += popcount(tmask).
  - This applies regardless of the wb flag.
  - Both counters wrap modulo 2^CTR_BITS.
- Reset values:
  - wb_valid=0, all wb_* payload=0.
  - commit_instrs=0, commit_threads=0, pointer=0.
  - res_ready is combinational, so it is 0 while reset is high; no grants occur during reset.
- Reset asserted mid-stream: the in-flight output register is cleared the next edge. Packets presented during reset are not consumed.
- A source lowering valid without being granted is legal (no assertion on source stability required).
- A zero tmask with eop=1: counts the instruction, adds 0 threads.

Decomposition:
- Shared package:
  - typedef wb_result_t (uuid, wid, tmask, pc, wb, rd, data, eop).
  - Source-index constants SRC_ALU=0, SRC_LSU=1, SRC_FPU=2, SRC_SFU=3.
- Sub-module wb_rr_arbiter (NUM_REQS parameter):
  - Inputs: requests. Outputs: one-hot grant, grant index, valid.
  - Contains the pointer register and its update on grant.
- The top holds the output register, payload mux and counters.

Test Plan:
- Single ALU packet (wid=1, rd=5, tmask=4'b1111, data=lane i → i+10, wb=1, eop=1) in cycle 3:
  - res_ready[0]=1 in cycle 3; wb_valid=1 with identical payload in cycle 4.
  - commit_instrs=1, commit_threads=4.
- All four sources valid continuously from reset release:
  - Grants in order 0,1,2,3,0,… one per cycle.
  - wb_valid every cycle; no source starved beyond 3 cycles.
- SFU packet with wb=0, eop=1, tmask=4'b0101:
  - Granted; next cycle wb_valid=0; commit_instrs +1, commit_threads +2.
- LSU two-beat instruction (eop=0 then eop=1) interleaved with ALU traffic:
  - Both LSU beats written back in arbitration order; commit_instrs increments once for the LSU instruction.
- Counter wrap with CTR_BITS=4: after 15 eop commits, a 16th gives commit_instrs=0.
- Reset asserted while wb_valid=1 and sources pending:
  - Next cycle wb_valid=0, counters 0, pointer 0.
  - No res_ready during reset; first grant after release goes to the lowest valid index.

Source files
------------

// File: rtl/writeback_commit_pkg.sv
// Shared definitions for the writeback commit stage: default widths,
// execute-unit source indices and the result packet record.
package writeback_commit_pkg;

  localparam int DEFAULT_NUM_SRCS    = 4;
  localparam int DEFAULT_NUM_THREADS = 4;
  localparam int DEFAULT_XLEN        = 32;
  localparam int DEFAULT_NW_WIDTH    = 2;
  localparam int DEFAULT_NR_BITS     = 6;
  localparam int DEFAULT_UUID_WIDTH  = 44;
  localparam int DEFAULT_CTR_BITS    = 44;

  // Result input index of each execute unit
  localparam int SRC_ALU = 0;
  localparam int SRC_LSU = 1;
  localparam int SRC_FPU = 2;
  localparam int SRC_SFU = 3;

  // One completed result beat as produced by an execute unit
  typedef struct packed {
    logic [DEFAULT_UUID_WIDTH-1:0]               uuid;
    logic [DEFAULT_NW_WIDTH-1:0]                 wid;
    logic [DEFAULT_NUM_THREADS-1:0]              tmask;
    logic [DEFAULT_XLEN-1:0]                     pc;
    logic                                        wb;
    logic [DEFAULT_NR_BITS-1:0]                  rd;
    logic [DEFAULT_NUM_THREADS*DEFAULT_XLEN-1:0] data;
    logic                                        eop;
  } wb_result_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle among active requests, searching
// from the priority pointer upward and wrapping; the pointer moves just past
// the winner so every requester is served within NUM_REQS cycles.
module wb_rr_arbiter
  import writeback_commit_pkg::*;
#(
  parameter int NUM_REQS = DEFAULT_NUM_SRCS,
  parameter int IDX_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] req,
  output logic [NUM_REQS-1:0] grant,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                grant_valid
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  int               idx;

  // Circular search starting at the pointer; first active request wins
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQS) begin
        idx = idx - NUM_REQS;
      end
      if (!grant_valid && req[idx]) begin
        grant[idx]  = 1'b1;
        grant_idx   = IDX_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

  // Pointer moves one past the winner, holds when nothing is granted
  always_comb begin
    ptr_d = ptr_q;
    if (grant_valid) begin
      if (int'(grant_idx) == NUM_REQS - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + IDX_W'(1);
      end
    end
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/writeback_commit.sv
// Per-issue-slot writeback collector: arbitrates execute-unit results, drives
// the registered writeback port (no back-pressure) and counts committed
// instructions and their active lanes.
module writeback_commit
  import writeback_commit_pkg::*;
#(
  parameter int NUM_SRCS    = DEFAULT_NUM_SRCS,
  parameter int NUM_THREADS = DEFAULT_NUM_THREADS,
  parameter int XLEN        = DEFAULT_XLEN,
  parameter int NW_WIDTH    = DEFAULT_NW_WIDTH,
  parameter int NR_BITS     = DEFAULT_NR_BITS,
  parameter int UUID_WIDTH  = DEFAULT_UUID_WIDTH,
  parameter int CTR_BITS    = DEFAULT_CTR_BITS
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_SRCS-1:0]                  res_valid,
  output logic [NUM_SRCS-1:0]                  res_ready,
  input  logic [NUM_SRCS*UUID_WIDTH-1:0]       res_uuid,
  input  logic [NUM_SRCS*NW_WIDTH-1:0]         res_wid,
  input  logic [NUM_SRCS*NUM_THREADS-1:0]      res_tmask,
  input  logic [NUM_SRCS*XLEN-1:0]             res_pc,
  input  logic [NUM_SRCS-1:0]                  res_wb,
  input  logic [NUM_SRCS*NR_BITS-1:0]          res_rd,
  input  logic [NUM_SRCS*NUM_THREADS*XLEN-1:0] res_data,
  input  logic [NUM_SRCS-1:0]                  res_eop,
  output logic                                 wb_valid,
  output logic [UUID_WIDTH-1:0]                wb_uuid,
  output logic [NW_WIDTH-1:0]                  wb_wid,
  output logic [NUM_THREADS-1:0]               wb_tmask,
  output logic [XLEN-1:0]                      wb_pc,
  output logic [NR_BITS-1:0]                   wb_rd,
  output logic [NUM_THREADS*XLEN-1:0]          wb_data,
  output logic                                 wb_eop,
  output logic [CTR_BITS-1:0]                  commit_instrs,
  output logic [CTR_BITS-1:0]                  commit_threads
);

  localparam int IDX_W  = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;
  localparam int DATA_W = NUM_THREADS * XLEN;

  logic [NUM_SRCS-1:0]    req;
  logic [NUM_SRCS-1:0]    grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_valid;

  int                     sel;
  logic [UUID_WIDTH-1:0]  sel_uuid;
  logic [NW_WIDTH-1:0]    sel_wid;
  logic [NUM_THREADS-1:0] sel_tmask;
  logic [XLEN-1:0]        sel_pc;
  logic                   sel_wb;
  logic [NR_BITS-1:0]     sel_rd;
  logic [DATA_W-1:0]      sel_data;
  logic                   sel_eop;
  logic [CTR_BITS-1:0]    lane_count;

  logic                   wb_valid_q, wb_valid_d;
  logic [UUID_WIDTH-1:0]  wb_uuid_q, wb_uuid_d;
  logic [NW_WIDTH-1:0]    wb_wid_q, wb_wid_d;
  logic [NUM_THREADS-1:0] wb_tmask_q, wb_tmask_d;
  logic [XLEN-1:0]        wb_pc_q, wb_pc_d;
  logic [NR_BITS-1:0]     wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]      wb_data_q, wb_data_d;
  logic                   wb_eop_q, wb_eop_d;
  logic [CTR_BITS-1:0]    commit_instrs_q, commit_instrs_d;
  logic [CTR_BITS-1:0]    commit_threads_q, commit_threads_d;

  // Requests are masked during reset so nothing is accepted while it is high
  always_comb begin
    req = reset ? '0 : res_valid;
  end

  wb_rr_arbiter #(
    .NUM_REQS (NUM_SRCS),
    .IDX_W    (IDX_W)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign res_ready = grant;

  // Select the granted source's payload and count its active lanes
  always_comb begin
    sel        = int'(grant_idx);
    sel_uuid   = res_uuid[sel*UUID_WIDTH +: UUID_WIDTH];
    sel_wid    = res_wid[sel*NW_WIDTH +: NW_WIDTH];
    sel_tmask  = res_tmask[sel*NUM_THREADS +: NUM_THREADS];
    sel_pc     = res_pc[sel*XLEN +: XLEN];
    sel_wb     = res_wb[sel];
    sel_rd     = res_rd[sel*NR_BITS +: NR_BITS];
    sel_data   = res_data[sel*DATA_W +: DATA_W];
    sel_eop    = res_eop[sel];
    lane_count = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      lane_count = lane_count + CTR_BITS'(sel_tmask[i]);
    end
  end

  // Output register and counters: payload loads on any grant, valid only
  // when the grantee writes a register; counters advance on end-of-packet
  always_comb begin
    wb_valid_d       = grant_valid & sel_wb;
    wb_uuid_d        = wb_uuid_q;
    wb_wid_d         = wb_wid_q;
    wb_tmask_d       = wb_tmask_q;
    wb_pc_d          = wb_pc_q;
    wb_rd_d          = wb_rd_q;
    wb_data_d        = wb_data_q;
    wb_eop_d         = wb_eop_q;
    commit_instrs_d  = commit_instrs_q;
    commit_threads_d = commit_threads_q;
    if (grant_valid) begin
      wb_uuid_d  = sel_uuid;
      wb_wid_d   = sel_wid;
      wb_tmask_d = sel_tmask;
      wb_pc_d    = sel_pc;
      wb_rd_d    = sel_rd;
      wb_data_d  = sel_data;
      wb_eop_d   = sel_eop;
      if (sel_eop) begin
        commit_instrs_d  = commit_instrs_q + CTR_BITS'(1);
        commit_threads_d = commit_threads_q + lane_count;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q       <= 1'b0;
      wb_uuid_q        <= '0;
      wb_wid_q         <= '0;
      wb_tmask_q       <= '0;
      wb_pc_q          <= '0;
      wb_rd_q          <= '0;
      wb_data_q        <= '0;
      wb_eop_q         <= 1'b0;
      commit_instrs_q  <= '0;
      commit_threads_q <= '0;
    end else begin
      wb_valid_q       <= wb_valid_d;
      wb_uuid_q        <= wb_uuid_d;
      wb_wid_q         <= wb_wid_d;
      wb_tmask_q       <= wb_tmask_d;
      wb_pc_q          <= wb_pc_d;
      wb_rd_q          <= wb_rd_d;
      wb_data_q        <= wb_data_d;
      wb_eop_q         <= wb_eop_d;
      commit_instrs_q  <= commit_instrs_d;
      commit_threads_q <= commit_threads_d;
    end
  end

  assign wb_valid       = wb_valid_q;
  assign wb_uuid        = wb_uuid_q;
  assign wb_wid         = wb_wid_q;
  assign wb_tmask       = wb_tmask_q;
  assign wb_pc          = wb_pc_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign wb_eop         = wb_eop_q;
  assign commit_instrs  = commit_instrs_q;
  assign commit_threads = commit_threads_q;

endmodule

// File: tb/tb_writeback_commit.sv
// Self-checking bench for writeback_commit: table vectors, directed
// multi-cycle sequences and random traffic against a behavioural model.
module tb_writeback_commit;
  import writeback_commit_pkg::*;

  localparam int NS = 4;
  localparam int NT = 4;
  localparam int XL = 32;
  localparam int NW = 2;
  localparam int NR = 6;
  localparam int UW = 44;
  localparam int CW = 44;
  localparam int DW = NT * XL;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [NS-1:0]     res_valid, res_ready, res_ready4, res_wb, res_eop;
  logic [NS*UW-1:0]  res_uuid;
  logic [NS*NW-1:0]  res_wid;
  logic [NS*NT-1:0]  res_tmask;
  logic [NS*XL-1:0]  res_pc;
  logic [NS*NR-1:0]  res_rd;
  logic [NS*DW-1:0]  res_data;

  logic              wb_valid, wb_eop, wb_valid4, wb_eop4;
  logic [UW-1:0]     wb_uuid, wb_uuid4;
  logic [NW-1:0]     wb_wid, wb_wid4;
  logic [NT-1:0]     wb_tmask, wb_tmask4;
  logic [XL-1:0]     wb_pc, wb_pc4;
  logic [NR-1:0]     wb_rd, wb_rd4;
  logic [DW-1:0]     wb_data, wb_data4;
  logic [CW-1:0]     commit_instrs, commit_threads;
  logic [3:0]        commit_instrs4, commit_threads4;

  writeback_commit dut (
    .clk(clk), .reset(reset),
    .res_valid(res_valid), .res_ready(res_ready), .res_uuid(res_uuid),
    .res_wid(res_wid), .res_tmask(res_tmask), .res_pc(res_pc), .res_wb(res_wb),
    .res_rd(res_rd), .res_data(res_data), .res_eop(res_eop),
    .wb_valid(wb_valid), .wb_uuid(wb_uuid), .wb_wid(wb_wid), .wb_tmask(wb_tmask),
    .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data), .wb_eop(wb_eop),
    .commit_instrs(commit_instrs), .commit_threads(commit_threads)
  );

  writeback_commit #(.CTR_BITS(4)) dut4 (
    .clk(clk), .reset(reset),
    .res_valid(res_valid), .res_ready(res_ready4), .res_uuid(res_uuid),
    .res_wid(res_wid), .res_tmask(res_tmask), .res_pc(res_pc), .res_wb(res_wb),
    .res_rd(res_rd), .res_data(res_data), .res_eop(res_eop),
    .wb_valid(wb_valid4), .wb_uuid(wb_uuid4), .wb_wid(wb_wid4), .wb_tmask(wb_tmask4),
    .wb_pc(wb_pc4), .wb_rd(wb_rd4), .wb_data(wb_data4), .wb_eop(wb_eop4),
    .commit_instrs(commit_instrs4), .commit_threads(commit_threads4)
  );

  // Stimulus sources and reference model state
  wb_result_t      src_pkt [NS];
  logic [NS-1:0]   src_valid;
  int              m_ptr;
  bit              m_wb_valid;
  wb_result_t      m_wb;
  longint unsigned m_instrs, m_threads;
  logic [NS-1:0]   exp_ready, last_ready;
  int              n_checks, n_fail;

  typedef struct {
    logic [NS-1:0] valid;
    logic [NS-1:0] exp_ready;
    logic          exp_wbv;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic wb_result_t rand_pkt();
    wb_result_t p;
    p.uuid  = UW'({$urandom, $urandom});
    p.wid   = NW'($urandom);
    p.tmask = NT'($urandom);
    p.pc    = $urandom;
    p.wb    = 1'($urandom);
    p.rd    = NR'($urandom);
    p.data  = {$urandom, $urandom, $urandom, $urandom};
    p.eop   = 1'($urandom);
    return p;
  endfunction

  // Drive the flat buses from the per-source records and check the grant
  task automatic applyStimulus();
    bit found;
    int i;
    for (int s = 0; s < NS; s++) begin
      res_valid[s]             = src_valid[s];
      res_uuid[s*UW +: UW]     = src_pkt[s].uuid;
      res_wid[s*NW +: NW]      = src_pkt[s].wid;
      res_tmask[s*NT +: NT]    = src_pkt[s].tmask;
      res_pc[s*XL +: XL]       = src_pkt[s].pc;
      res_wb[s]                = src_pkt[s].wb;
      res_rd[s*NR +: NR]       = src_pkt[s].rd;
      res_data[s*DW +: DW]     = src_pkt[s].data;
      res_eop[s]               = src_pkt[s].eop;
    end
    #1;
    exp_ready = '0;
    found = 1'b0;
    if (!reset) begin
      for (int k = 0; k < NS; k++) begin
        i = (m_ptr + k) % NS;
        if (!found && src_valid[i]) begin
          exp_ready[i] = 1'b1;
          found = 1'b1;
        end
      end
    end
    last_ready = res_ready;
    chk("res_ready", 128'(res_ready), 128'(exp_ready));
    chk("res_ready_c4", 128'(res_ready4), 128'(exp_ready));
  endtask

  task automatic checkOutput();
    chk("wb_valid", 128'(wb_valid), 128'(m_wb_valid));
    chk("wb_uuid", 128'(wb_uuid), 128'(m_wb.uuid));
    chk("wb_wid", 128'(wb_wid), 128'(m_wb.wid));
    chk("wb_tmask", 128'(wb_tmask), 128'(m_wb.tmask));
    chk("wb_pc", 128'(wb_pc), 128'(m_wb.pc));
    chk("wb_rd", 128'(wb_rd), 128'(m_wb.rd));
    chk("wb_data", 128'(wb_data), 128'(m_wb.data));
    chk("wb_eop", 128'(wb_eop), 128'(m_wb.eop));
    chk("commit_instrs", 128'(commit_instrs), 128'(m_instrs % (64'd1 << CW)));
    chk("commit_threads", 128'(commit_threads), 128'(m_threads % (64'd1 << CW)));
    chk("c4_valid", 128'(wb_valid4), 128'(m_wb_valid));
    chk("c4_payload", {wb_uuid4, wb_wid4, wb_tmask4, wb_pc4, wb_rd4, wb_eop4},
        {m_wb.uuid, m_wb.wid, m_wb.tmask, m_wb.pc, m_wb.rd, m_wb.eop});
    chk("c4_data", 128'(wb_data4), 128'(m_wb.data));
    chk("c4_instrs", 128'(commit_instrs4), 128'(m_instrs % 16));
    chk("c4_threads", 128'(commit_threads4), 128'(m_threads % 16));
  endtask

  // One clock: drive, check grant, advance the model at the edge, check outputs
  task automatic stepCycle();
    int g;
    applyStimulus();
    @(posedge clk);
    g = -1;
    for (int s = 0; s < NS; s++) if (exp_ready[s]) g = s;
    if (reset) begin
      m_ptr = 0; m_wb_valid = 1'b0; m_wb = '0; m_instrs = 0; m_threads = 0;
    end else if (g >= 0) begin
      m_ptr = (g + 1) % NS;
      m_wb_valid = src_pkt[g].wb;
      m_wb = src_pkt[g];
      if (src_pkt[g].eop) begin
        m_instrs++;
        m_threads += longint'($countones(src_pkt[g].tmask));
      end
    end else begin
      m_wb_valid = 1'b0;
    end
    #1;
    checkOutput();
  endtask

  task automatic resetDut();
    reset = 1'b1;
    src_valid = '0;
    stepCycle();
    stepCycle();
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    longint unsigned b_instrs, b_threads;
    int beat;
    n_checks = 0; n_fail = 0;
    m_ptr = 0; m_wb_valid = 1'b0; m_wb = '0; m_instrs = 0; m_threads = 0;
    for (int s = 0; s < NS; s++) src_pkt[s] = '0;
    src_valid = '0;
    reset = 1'b1;

    // Single ALU packet presented in the third cycle after reset release
    resetDut();
    stepCycle();
    stepCycle();
    src_pkt[SRC_ALU] = '{uuid: 44'h123, wid: 2'd1, tmask: 4'b1111, pc: 32'h1000, wb: 1'b1,
                         rd: 6'd5, data: {32'd13, 32'd12, 32'd11, 32'd10}, eop: 1'b1};
    src_valid = 4'b0001;
    stepCycle();
    chk("alu_ready", 128'(last_ready), 128'(4'b0001));
    chk("alu_wbv", 128'(wb_valid), 128'(1'b1));
    chk("alu_rd", 128'(wb_rd), 128'(6'd5));
    chk("alu_wid", 128'(wb_wid), 128'(2'd1));
    chk("alu_data", 128'(wb_data), {32'd13, 32'd12, 32'd11, 32'd10});
    chk("alu_instrs", 128'(commit_instrs), 128'(1));
    chk("alu_threads", 128'(commit_threads), 128'(4));
    src_valid = '0;
    stepCycle();
    chk("idle_wbv", 128'(wb_valid), 128'(1'b0));
    chk("idle_hold_rd", 128'(wb_rd), 128'(6'd5));

    // Table vectors from a fresh pointer
    tbl[0] = '{4'b0001, 4'b0001, 1'b1};
    tbl[1] = '{4'b0001, 4'b0001, 1'b1};
    tbl[2] = '{4'b1111, 4'b0010, 1'b1};
    tbl[3] = '{4'b1011, 4'b1000, 1'b1};
    tbl[4] = '{4'b0110, 4'b0010, 1'b1};
    tbl[5] = '{4'b0000, 4'b0000, 1'b0};
    tbl[6] = '{4'b0101, 4'b0100, 1'b1};
    tbl[7] = '{4'b0101, 4'b0001, 1'b1};
    resetDut();
    for (int v = 0; v < 8; v++) begin
      for (int s = 0; s < NS; s++) begin
        src_pkt[s] = rand_pkt();
        src_pkt[s].wb = 1'b1;
      end
      src_valid = tbl[v].valid;
      stepCycle();
      chk("tbl_ready", 128'(last_ready), 128'(tbl[v].exp_ready));
      chk("tbl_wbv", 128'(wb_valid), 128'(tbl[v].exp_wbv));
    end

    // All sources valid from reset release: strict rotation, output every cycle
    resetDut();
    src_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      for (int s = 0; s < NS; s++) begin
        src_pkt[s] = rand_pkt();
        src_pkt[s].wb = 1'b1;
        src_pkt[s].eop = 1'b1;
      end
      stepCycle();
      chk("rr_order", 128'(last_ready), 128'(4'b0001 << (k % 4)));
      chk("rr_wbv", 128'(wb_valid), 128'(1'b1));
    end

    // SFU result without register write still commits
    b_instrs = m_instrs; b_threads = m_threads;
    src_pkt[SRC_SFU] = rand_pkt();
    src_pkt[SRC_SFU].wb = 1'b0;
    src_pkt[SRC_SFU].eop = 1'b1;
    src_pkt[SRC_SFU].tmask = 4'b0101;
    src_valid = 4'b1000;
    stepCycle();
    chk("sfu_ready", 128'(last_ready), 128'(4'b1000));
    chk("sfu_wbv", 128'(wb_valid), 128'(1'b0));
    chk("sfu_instrs", 128'(commit_instrs), 128'(b_instrs + 1));
    chk("sfu_threads", 128'(commit_threads), 128'(b_threads + 2));

    // Two-beat LSU instruction interleaved with ALU beats
    b_instrs = m_instrs;
    beat = 0;
    src_pkt[SRC_LSU] = rand_pkt();
    src_pkt[SRC_LSU].rd = 6'd7; src_pkt[SRC_LSU].wb = 1'b1; src_pkt[SRC_LSU].eop = 1'b0;
    for (int c = 0; c < 8 && beat < 2; c++) begin
      src_pkt[SRC_ALU] = rand_pkt();
      src_pkt[SRC_ALU].eop = 1'b0;
      src_valid = 4'b0011;
      stepCycle();
      if (last_ready[SRC_LSU]) begin
        chk("lsu_rd", 128'(wb_rd), 128'(6'd7));
        chk("lsu_wbv", 128'(wb_valid), 128'(1'b1));
        beat++;
        src_pkt[SRC_LSU].eop = 1'b1;
        src_pkt[SRC_LSU].data = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    chk("lsu_beats", 128'(beat), 128'(2));
    chk("lsu_instrs", 128'(commit_instrs), 128'(b_instrs + 1));

    // Counter wrap on the 4-bit instance
    resetDut();
    src_pkt[SRC_ALU] = rand_pkt();
    src_pkt[SRC_ALU].eop = 1'b1;
    src_valid = 4'b0001;
    for (int k = 1; k <= 16; k++) begin
      stepCycle();
      if (k == 15) chk("wrap15", 128'(commit_instrs4), 128'(15));
    end
    chk("wrap16", 128'(commit_instrs4), 128'(0));
    chk("wrap16_wide", 128'(commit_instrs), 128'(16));

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      src_valid = NS'($urandom);
      for (int s = 0; s < NS; s++) src_pkt[s] = rand_pkt();
      stepCycle();
    end

    // Reset asserted mid-stream with sources still pending
    src_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < NS; s++) begin
        src_pkt[s] = rand_pkt();
        src_pkt[s].wb = 1'b1;
      end
      stepCycle();
    end
    chk("pre_rst_wbv", 128'(wb_valid), 128'(1'b1));
    reset = 1'b1;
    stepCycle();
    chk("rst_ready", 128'(last_ready), 128'(0));
    chk("rst_wbv", 128'(wb_valid), 128'(1'b0));
    chk("rst_instrs", 128'(commit_instrs), 128'(0));
    chk("rst_threads", 128'(commit_threads), 128'(0));
    stepCycle();
    chk("rst_ready2", 128'(last_ready), 128'(0));
    reset = 1'b0;
    src_valid = 4'b1110;
    stepCycle();
    chk("post_rst_grant", 128'(last_ready), 128'(4'b0010));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
